// File: rtl/link_pkg.sv
// Shared types and widths for the link test checker.
package link_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/idle_timer.sv
// Idle watchdog: reloads on clr, counts down while enabled, flags zero.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/link_checker.sv
// Checks received words against the incrementing pattern and reports
// pass/fail/timeout once the run completes or stalls.
module link_checker
  import link_pkg::*;
#(
  parameter int          WORD_COUNT     = 100,
  parameter logic [31:0] SEED           = 32'h0000_0001,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic              led,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err_idx
);
  localparam logic [CNT_W-1:0] WC   = CNT_W'(WORD_COUNT);
  localparam logic [CNT_W-1:0] NONE = '1;

  state_t            state;
  logic [DATA_W-1:0] expected;
  logic              expired;
  logic              mism;
  logic              last;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  err_nxt;

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state != RUN) || rx_valid),
    .en     (state == RUN),
    .expired(expired)
  );

  always_comb begin
    mism    = (rx_data != expected);
    cnt_nxt = rx_count + CNT_W'(1);
    last    = (cnt_nxt == WC);
    err_nxt = err_count;
    if (mism && err_count != NONE) begin
      err_nxt = err_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      expected      <= SEED;
      busy          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      led           <= 1'b0;
      rx_count      <= '0;
      err_count     <= '0;
      first_err_idx <= NONE;
    end else if (!en) begin
      // Abort or rearm: en low wins over any word or timeout.
      state         <= IDLE;
      busy          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      led           <= 1'b0;
      rx_count      <= '0;
      err_count     <= '0;
      first_err_idx <= NONE;
    end else begin
      unique case (state)
        IDLE: begin
          state         <= RUN;
          busy          <= 1'b1;
          expected      <= SEED;
          rx_count      <= '0;
          err_count     <= '0;
          first_err_idx <= NONE;
        end
        RUN: begin
          if (rx_valid) begin
            // Resync to the received word so a slip costs one error.
            expected  <= rx_data + 32'd1;
            rx_count  <= cnt_nxt;
            err_count <= err_nxt;
            if (mism && first_err_idx == NONE) begin
              first_err_idx <= rx_count;
            end
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              pass  <= (err_nxt == '0);
              led   <= (err_nxt == '0);
              fail  <= (err_nxt != '0);
            end
          end else if (expired) begin
            state   <= DONE;
            busy    <= 1'b0;
            timeout <= 1'b1;
            fail    <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_link_checker.sv
// Directed vector bench for link_checker: table for a short-run
// instance, hand sequences for the 100-word instance.
module tb_link_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        en = 1'b0;
  logic        v = 1'b0;
  logic [31:0] d = '0;
  logic        busy, pass, fail, tmo, led;
  logic [15:0] cnt, err, first;

  logic        en_w = 1'b0;
  logic        v_w = 1'b0;
  logic [31:0] d_w = '0;
  logic        busy_w, pass_w, fail_w, tmo_w, led_w;
  logic [15:0] cnt_w, err_w, first_w;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  link_checker #(
    .WORD_COUNT(100),
    .SEED(32'h0000_0001),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .rx_valid(v), .rx_data(d),
    .busy(busy), .pass(pass), .fail(fail),
    .timeout(tmo), .led(led),
    .rx_count(cnt), .err_count(err),
    .first_err_idx(first)
  );

  link_checker #(
    .WORD_COUNT(4),
    .SEED(32'hFFFF_FFFE),
    .TIMEOUT_CYCLES(50)
  ) dut_w (
    .clk(clk), .rst(rst), .en(en_w),
    .rx_valid(v_w), .rx_data(d_w),
    .busy(busy_w), .pass(pass_w), .fail(fail_w),
    .timeout(tmo_w), .led(led_w),
    .rx_count(cnt_w), .err_count(err_w),
    .first_err_idx(first_w)
  );

  typedef struct {
    logic        en;
    logic        v;
    logic [31:0] d;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [15:0] cnt;
    logic [15:0] err;
    logic [15:0] first;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic cyc(input logic e, input logic vv, input logic [31:0] dd);
    @(negedge clk);
    en = e;
    v  = vv;
    d  = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("start_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic feed(input int n, input int bad_idx);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b1, (i == bad_idx) ? 32'hDEAD_BEEF : 32'(i + 1));
      if (i == 0) chk("first_latency_cnt", {16'b0, cnt}, 32'd1);
    end
    @(negedge clk);
    v = 1'b0;
  endtask

  task automatic chk_done(input string tag, input logic p,
                          input logic [15:0] c, input logic [15:0] e,
                          input logic [15:0] f);
    chk({tag, "_pass"}, {31'b0, pass}, {31'b0, p});
    chk({tag, "_fail"}, {31'b0, fail}, {31'b0, ~p});
    chk({tag, "_led"}, {31'b0, led}, {31'b0, p});
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_cnt"}, {16'b0, cnt}, {16'b0, c});
    chk({tag, "_err"}, {16'b0, err}, {16'b0, e});
    chk({tag, "_first"}, {16'b0, first}, {16'b0, f});
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_pass"}, {31'b0, pass}, 32'd0);
    chk({tag, "_fail"}, {31'b0, fail}, 32'd0);
    chk({tag, "_tmo"}, {31'b0, tmo}, 32'd0);
    chk({tag, "_led"}, {31'b0, led}, 32'd0);
    chk({tag, "_cnt"}, {16'b0, cnt}, 32'd0);
    chk({tag, "_err"}, {16'b0, err}, 32'd0);
    chk({tag, "_first"}, {16'b0, first}, 32'h0000_FFFF);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'hFFFF};
    tbl[1]  = '{1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 16'hFFFF};
    tbl[2]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 16'd2, 16'd0, 16'hFFFF};
    tbl[3]  = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 16'd3, 16'd0, 16'hFFFF};
    tbl[4]  = '{1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 16'd4, 16'd0, 16'hFFFF};
    tbl[5]  = '{1'b1, 1'b1, 32'h0000_0005, 1'b0, 1'b1, 1'b0, 16'd4, 16'd0, 16'hFFFF};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'hFFFF};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'hFFFF};
    tbl[8]  = '{1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 16'hFFFF};
    tbl[9]  = '{1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 16'd2, 16'd1, 16'd1};
    tbl[10] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 16'd3, 16'd1, 16'd1};
    tbl[11] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 16'd4, 16'd2, 16'd1};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'hFFFF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_clear("reset");
    chk("reset_w_first", {16'b0, first_w}, 32'h0000_FFFF);
    @(negedge clk);
    rst = 1'b1;

    // Wrap-around table on the 4-word instance
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      en_w = tbl[i].en;
      v_w  = tbl[i].v;
      d_w  = tbl[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("w%0d_busy", i), {31'b0, busy_w}, {31'b0, tbl[i].busy});
      chk($sformatf("w%0d_pass", i), {31'b0, pass_w}, {31'b0, tbl[i].pass});
      chk($sformatf("w%0d_led", i), {31'b0, led_w}, {31'b0, tbl[i].pass});
      chk($sformatf("w%0d_fail", i), {31'b0, fail_w}, {31'b0, tbl[i].fail});
      chk($sformatf("w%0d_tmo", i), {31'b0, tmo_w}, 32'd0);
      chk($sformatf("w%0d_cnt", i), {16'b0, cnt_w}, {16'b0, tbl[i].cnt});
      chk($sformatf("w%0d_err", i), {16'b0, err_w}, {16'b0, tbl[i].err});
      chk($sformatf("w%0d_first", i), {16'b0, first_w}, {16'b0, tbl[i].first});
    end

    // Clean run
    start();
    feed(100, -1);
    chk_done("clean", 1'b1, 16'd100, 16'd0, 16'hFFFF);
    chk("clean_tmo", {31'b0, tmo}, 32'd0);

    // Corrupted word at index 10
    start();
    feed(100, 10);
    chk_done("corrupt", 1'b0, 16'd100, 16'd2, 16'd10);

    // Timeout: 3 words then silence
    start();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'(i + 1));
    for (int k = 1; k <= 51; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      if (k == 50) begin
        chk("tmo_early", {31'b0, tmo}, 32'd0);
        chk("tmo_early_busy", {31'b0, busy}, 32'd1);
      end
    end
    chk("tmo_flag", {31'b0, tmo}, 32'd1);
    chk("tmo_fail", {31'b0, fail}, 32'd1);
    chk("tmo_pass", {31'b0, pass}, 32'd0);
    chk("tmo_busy", {31'b0, busy}, 32'd0);
    chk("tmo_cnt", {16'b0, cnt}, 32'd3);

    // Abort after 40 words; the word in the abort cycle is ignored
    start();
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 32'(i + 1));
    chk("abort_pre_cnt", {16'b0, cnt}, 32'd40);
    cyc(1'b0, 1'b1, 32'd41);
    chk_clear("abort");
    start();
    feed(100, -1);
    chk_done("rerun", 1'b1, 16'd100, 16'd0, 16'hFFFF);

    // Asynchronous reset mid-run
    start();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 32'(i + 1));
    @(negedge clk);
    v = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_clear("async_rst");
    @(negedge clk);
    rst = 1'b1;
    start();
    feed(100, -1);
    chk_done("post_rst", 1'b1, 16'd100, 16'd0, 16'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/link_checker.md
# link_checker

Receive-side verification stage for the FPGA-to-FPGA link test. It sits directly downstream of `fpga2_receiver` and consumes each word that receiver accepts. It checks the words against the incrementing pattern produced by the sender-side generator, and counts words and errors. It drives the board LED and pass/fail flags once a configured number of words has arrived or the link stalls.

## Interface
Parameters:
- `WORD_COUNT`, 100: words expected per test run; range 1..65535.
- `SEED`, 32'h0000_0001: value of the first expected word.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle cycles between accepted words while running; range ≥1.

Ports:
- `clk` in 1: single system clock, shared with sender and receiver.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: test enable, level-sensitive; high runs a test, low aborts or rearms.
- `rx_valid` in 1: one-cycle strobe, high when the receiver accepts a word (`req_in && ack_out`).
- `rx_data` in 32: word accepted by the receiver, valid when `rx_valid` is high.
- `busy` out 1: high in RUN.
- `pass` out 1: high in DONE when the run ended with all words received, zero errors and no timeout.
- `fail` out 1: high in DONE otherwise.
- `timeout` out 1: high in DONE when the run ended by timeout.
- `led` out 1: equals `pass`, registered.
- `rx_count` out 16: words accepted this run.
- `err_count` out 16: mismatching words this run; saturates at 16'hFFFF.
- `first_err_idx` out 16: index of the first mismatching word; 16'hFFFF if none.

## Operation
States:
- **IDLE**
  - `en`=1 → RUN.
  - On that transition: `expected`←SEED, counts←0, `first_err_idx`←FFFF, timer←0.
- **RUN**
  - On `rx_valid`, compare `rx_data` with `expected`.
  - Mismatch: `err_count`+1 (saturating). If `first_err_idx`==FFFF, capture the current `rx_count`.
  - After every word, match or not: `expected`←`rx_data`+1, mod 2^32, so a dropped or inserted word costs one error rather than a cascade. A single corrupted word costs two errors.
  - `rx_count`+1 on every `rx_valid`.
  - Leave for DONE when the accepted word is number `WORD_COUNT`, or on timeout.
  - `en`=0 → IDLE immediately. All outputs clear; `rx_valid` in that cycle is ignored.
- **DONE**
  - All outputs hold.
  - `rx_valid` is ignored.
  - `en`=0 → IDLE.

Timeout:
- An idle timer counts RUN cycles without `rx_valid` and clears on every `rx_valid`.
- When the timer reaches `TIMEOUT_CYCLES` → DONE with `timeout`=1 and `fail`=1.

Arithmetic:
- `expected` wraps FFFF_FFFF→0000_0000 with no error.
- `rx_count` never exceeds `WORD_COUNT`.

Simultaneous events:
- `en` low beats `rx_valid` and timeout.
- Final word beats timeout in the same cycle; the run counts as complete.

Reset values (all outputs): state IDLE, `busy`/`pass`/`fail`/`timeout`/`led` 0, counts 0, `first_err_idx` FFFF. Asserting `rst` mid-run returns everything to these values asynchronously.

## Timing
- All outputs are registered; each takes effect one clock after the triggering input edge.
- Compare latency is 1 cycle: `rx_valid` at edge N updates `rx_count`/`err_count` at N+1.
- Final word at edge N: state = DONE and `pass`/`fail`/`led` are valid at N+1; `busy` falls at N+1.
- `en` rising at edge N: `busy`=1 at N+1; the first `rx_valid` is checked from N+1.
- Timeout: the last `rx_valid` at edge N, then none, gives `timeout`=1 at edge N+TIMEOUT_CYCLES+1.
- Back-to-back `rx_valid` on every cycle is supported at full rate.

## Structure
- Package `link_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - `DATA_W`=32;
  - `CNT_W`=16.
- Sub-module `idle_timer` is the natural split: a clear/enable down-counter with `expired` output, parameterised by `TIMEOUT_CYCLES`.
- The FSM, comparator and counters live in `link_checker`.
- The top level instantiates `link_checker` with `rx_valid` = `i_req_rx && o_ack_rx` and `rx_data` = `do_2`.

## Test plan
- **Clean run:** `WORD_COUNT`=100, `en`=1, feed 1..100 one per cycle. Expect `pass`=`led`=1, `rx_count`=100, `err_count`=0, `first_err_idx`=FFFF.
- **Corrupted word:** feed 1..100 with word index 10 replaced by 32'hDEAD_BEEF. Expect `fail`=1, `err_count`=2, `first_err_idx`=10.
- **Wrap-around:** `SEED`=32'hFFFF_FFFE, `WORD_COUNT`=4, feed FFFF_FFFE, FFFF_FFFF, 0, 1. Expect `pass`=1.
- **Timeout:** `TIMEOUT_CYCLES`=50, feed 3 words then stop. Expect `timeout`=`fail`=1 exactly 51 cycles after the last `rx_valid`, with `rx_count`=3.
- **Abort:** drop `en` after 40 words. Expect IDLE next cycle with all outputs zero. Raise `en` again and run clean: `pass`=1.
- **Reset mid-run:** assert `rst` low asynchronously during RUN. Outputs clear without a clock edge; a new run after release passes.
